// File: rtl/noc_packet_injector.sv
// noc_packet_injector: turns a (destination, length) request plus a stream of
// 28-bit payload words into a header/body/tail flit packet for a router local
// input port, with even parity in bit 0 of every flit.
//
// Ports:
//   clk, rst             clock (rising edge), async active-low reset
//   cur_addr             own node address, static after reset
//   req_valid/req_ready  packet request handshake; req_dst, req_len (N) payload
//   pay_valid/pay_ready  payload word handshake; pay_data word
//   TX, RTS              registered flit and one-cycle strobe to the router
//   DCTS                 router input FIFO ready
//   pkt_sent             one-cycle pulse alongside the tail flit's RTS
//   err                  one-cycle pulse when a request length is rejected
module noc_packet_injector #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cur_addr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_dst,
  input  logic [11:0]           req_len,
  input  logic                  pay_valid,
  output logic                  pay_ready,
  input  logic [27:0]           pay_data,
  output logic [DATA_WIDTH-1:0] TX,
  output logic                  RTS,
  input  logic                  DCTS,
  output logic                  pkt_sent,
  output logic                  err
);

  localparam int unsigned LEN_W = 12;
  localparam int unsigned SEQ_W = 8;

  localparam logic [2:0]       TYPE_HDR  = 3'b001;
  localparam logic [2:0]       TYPE_BODY = 3'b010;
  localparam logic [2:0]       TYPE_TAIL = 3'b100;
  localparam logic [LEN_W-1:0] LEN_MAX   = 12'hFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAY
  } state_t;

  state_t           r_state;
  logic [3:0]       r_dst;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [SEQ_W-1:0] r_seq;
  logic [31:0]      r_tx;
  logic             r_rts;
  logic             r_pkt_sent;
  logic             r_err;

  logic             w_last;
  logic [31:0]      w_hdr_flit;
  logic [31:0]      w_pay_flit;

  // Append the even-parity bit so the XOR of all 32 flit bits is zero.
  function automatic logic [31:0] add_parity(input logic [30:0] f);
    return {f, ^f};
  endfunction

  // Remaining count of one means the word being consumed ends the packet.
  assign w_last     = (r_cnt <= LEN_W'(1));
  assign w_hdr_flit = add_parity({TYPE_HDR, LEN_W'(r_len + LEN_W'(1)), r_dst, cur_addr, r_seq});
  assign w_pay_flit = add_parity({(w_last ? TYPE_TAIL : TYPE_BODY), pay_data});

  // Handshake readies decode straight from state; payload follows router credit.
  assign req_ready = (r_state == S_IDLE);
  assign pay_ready = (r_state == S_PAY) && DCTS;

  assign TX       = DATA_WIDTH'(r_tx);
  assign RTS      = r_rts;
  assign pkt_sent = r_pkt_sent;
  assign err      = r_err;

  // Packet FSM with registered flit outputs; strobes default low every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_dst      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_seq      <= '0;
      r_tx       <= '0;
      r_rts      <= 1'b0;
      r_pkt_sent <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rts      <= 1'b0;
      r_pkt_sent <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_dst <= req_dst;
            r_len <= req_len;
            // Zero-length packets and lengths whose total overflows the field are refused.
            if ((req_len == '0) || (req_len == LEN_MAX)) begin
              r_err <= 1'b1;
            end else begin
              r_state <= S_HDR;
            end
          end
        end
        S_HDR: begin
          if (DCTS) begin
            r_tx    <= w_hdr_flit;
            r_rts   <= 1'b1;
            r_cnt   <= r_len;
            r_state <= S_PAY;
          end
        end
        S_PAY: begin
          if (pay_valid && DCTS) begin
            r_tx  <= w_pay_flit;
            r_rts <= 1'b1;
            r_cnt <= r_cnt - LEN_W'(1);
            if (w_last) begin
              r_pkt_sent <= 1'b1;
              r_seq      <= r_seq + SEQ_W'(1);
              r_state    <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Scoreboard bench for noc_packet_injector: requests push whole expected
// packets (built from the flit layout rules) into a queue, and an independent
// monitor pops one entry per RTS strobe and compares it.
module tb_noc_packet_injector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  cur_addr = 4'd1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_dst = '0;
  logic [11:0] req_len = '0;
  logic        pay_valid = 1'b0;
  logic        pay_ready;
  logic [27:0] pay_data = '0;
  logic [31:0] TX;
  logic        RTS;
  logic        DCTS = 1'b1;
  logic        pkt_sent;
  logic        err;

  noc_packet_injector #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cur_addr(cur_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_dst(req_dst), .req_len(req_len),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .TX(TX), .RTS(RTS), .DCTS(DCTS), .pkt_sent(pkt_sent), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] flit;
    logic        tail;
  } exp_t;

  exp_t        exp_q[$];
  logic [27:0] pay_q[$];
  exp_t        mon_e;

  int checks = 0;
  int errors = 0;
  int err_exp = 0;
  int ncyc = 0;
  int rts_seen = 0;
  int acc_cyc = 0;
  int hdr_cyc = 0;
  int tail_cyc = 0;
  logic [31:0] last_hdr = '0;
  logic [31:0] last_tx = '0;
  logic [7:0]  seq_m = '0;
  bit rand_dcts = 0;
  bit bubbles = 0;
  bit manual_dcts = 0;
  logic hs_e = 1'b0;
  logic dcts_e = 1'b0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Even parity over the 31 content bits, counted rather than reduced.
  function automatic logic [31:0] mk(input logic [30:0] f);
    return {f, 1'($countones(f) % 2)};
  endfunction

  // Reference: an accepted request becomes an err event or a full flit list.
  task automatic model(input logic [3:0] d, input logic [11:0] n, input bit inc_pay);
    logic [27:0] w;
    if (n == 12'd0 || n == 12'd4095) begin
      err_exp++;
    end else begin
      exp_q.push_back('{flit: mk({3'b001, 12'(n + 12'd1), d, cur_addr, seq_m}), tail: 1'b0});
      for (int i = 0; i < int'(n); i++) begin
        w = inc_pay ? 28'(i + 1) : 28'($urandom);
        pay_q.push_back(w);
        exp_q.push_back('{flit: mk({(i == int'(n) - 1) ? 3'b100 : 3'b010, w}),
                          tail: (i == int'(n) - 1)});
      end
      seq_m = seq_m + 8'd1;
    end
  endtask

  task automatic send(input logic [3:0] d, input logic [11:0] n, input bit inc_pay);
    bit got = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_dst   = d;
    req_len   = n;
    for (int i = 0; i < 15000 && !got; i++) begin
      @(posedge clk);
      if (req_ready) got = 1;
    end
    if (got) begin
      acc_cyc = ncyc;
      model(d, n, inc_pay);
    end else begin
      check(0, "req_accept_timeout", 32'(req_ready), 32'd1);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && pay_q.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    check(exp_q.size() == 0, "drain_flits_left", 32'(exp_q.size()), 32'd0);
    check(err_exp == 0, "err_pulses_missing", 32'(err_exp), 32'd0);
  endtask

  // Handshake and credit as seen at the active edge.
  always @(posedge clk) begin
    hs_e   <= pay_valid && pay_ready;
    dcts_e <= DCTS;
  end

  // Payload source, optionally with random bubbles.
  initial forever begin
    @(negedge clk);
    if (rst && pay_q.size() > 0 && (!bubbles || $urandom_range(3) != 0)) begin
      pay_valid = 1'b1;
      pay_data  = pay_q[0];
    end else begin
      pay_valid = 1'b0;
    end
    @(posedge clk);
    if (pay_valid && pay_ready && pay_q.size() > 0) void'(pay_q.pop_front());
  end

  // Router credit, steady or random unless a test drives it directly.
  initial forever begin
    @(negedge clk);
    if (!manual_dcts) DCTS = rand_dcts ? ($urandom_range(3) != 0) : 1'b1;
  end

  // Monitor: pops one expected flit per strobe and checks per-cycle rules.
  initial forever begin
    @(negedge clk);
    ncyc++;
    if (!rst) begin
      last_tx = '0;
    end else begin
      if (RTS) begin
        rts_seen++;
        check((^TX) == 1'b0, "flit_parity", TX, 32'd0);
        check(dcts_e == 1'b1, "rts_without_dcts", 32'(dcts_e), 32'd1);
        if (exp_q.size() == 0) begin
          check(0, "unexpected_flit", TX, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check(TX == mon_e.flit, "flit_value", TX, mon_e.flit);
          check(pkt_sent == mon_e.tail, "pkt_sent_with_flit", 32'(pkt_sent), 32'(mon_e.tail));
          if (mon_e.flit[31:29] == 3'b001) begin
            last_hdr = TX;
            hdr_cyc  = ncyc;
          end
          if (mon_e.tail) tail_cyc = ncyc;
        end
        last_tx = TX;
      end else begin
        check(TX == last_tx, "tx_hold", TX, last_tx);
        check(pkt_sent == 1'b0, "pkt_sent_without_rts", 32'(pkt_sent), 32'd0);
        check(hs_e == 1'b0, "payload_to_rts_latency", 32'(RTS), 32'd1);
      end
      if (err) check(err_exp > 0, "unexpected_err", 32'(err), 32'd0);
      if (err && err_exp > 0) err_exp--;
      check(DCTS || !pay_ready, "pay_ready_without_dcts", 32'(pay_ready), 32'd0);
    end
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check(RTS == 1'b0, "reset_rts", 32'(RTS), 32'd0);
    check(TX == 32'd0, "reset_tx", TX, 32'd0);
    check(pkt_sent == 1'b0 && err == 1'b0, "reset_pulses", 32'({pkt_sent, err}), 32'd0);
    check(pay_ready == 1'b0, "reset_pay_ready", 32'(pay_ready), 32'd0);
    rst = 1'b1;
    #1;
    check(req_ready == 1'b1, "req_ready_after_reset", 32'(req_ready), 32'd1);

    // Basic packet with known payload words.
    send(4'd2, 12'd3, 1);
    drain();
    check(last_hdr == 32'h20084200, "basic_header", last_hdr, 32'h20084200);
    check(hdr_cyc - acc_cyc == 2, "req_to_header_latency", 32'(hdr_cyc - acc_cyc), 32'd2);
    check(tail_cyc - hdr_cyc == 3, "back_to_back_flits", 32'(tail_cyc - hdr_cyc), 32'd3);

    // Destination equal to own address, then boundary lengths.
    send(4'd1, 12'd2, 0);
    send(4'd5, 12'd1, 0);
    drain();
    check(last_hdr[28:17] == 12'd2, "len1_total_field", 32'(last_hdr[28:17]), 32'd2);
    send(4'd5, 12'd0, 0);
    send(4'd6, 12'd4095, 0);
    drain();

    // Backpressure mid-payload for five cycles.
    base = rts_seen;
    send(4'd3, 12'd10, 0);
    for (int i = 0; i < 200 && rts_seen < base + 4; i++) @(negedge clk);
    manual_dcts = 1;
    DCTS = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check(RTS == 1'b0, "stall_rts", 32'(RTS), 32'd0);
      check(pay_ready == 1'b0, "stall_pay_ready", 32'(pay_ready), 32'd0);
    end
    DCTS = 1'b1;
    manual_dcts = 0;
    drain();

    // Longest legal packet under random credit and payload bubbles.
    rand_dcts = 1;
    bubbles = 1;
    send(4'($urandom_range(15)), 12'd4094, 0);
    drain();
    check(last_hdr[28:17] == 12'd4095, "len4094_total_field", 32'(last_hdr[28:17]), 32'd4095);

    // Random mix including rejected lengths.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(7))
        0: send(4'($urandom_range(15)), 12'd0, 0);
        1: send(4'($urandom_range(15)), 12'd4095, 0);
        default: send(4'($urandom_range(15)), 12'($urandom_range(20, 1)), 0);
      endcase
    end
    drain();

    // Reset after the header and one body flit.
    rand_dcts = 0;
    bubbles = 0;
    base = rts_seen;
    send(4'd4, 12'd5, 0);
    for (int i = 0; i < 200 && rts_seen < base + 2; i++) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check(RTS == 1'b0, "async_reset_rts", 32'(RTS), 32'd0);
    check(TX == 32'd0, "async_reset_tx", TX, 32'd0);
    exp_q.delete();
    pay_q.delete();
    pay_valid = 1'b0;
    err_exp = 0;
    seq_m = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check(req_ready == 1'b1, "req_ready_after_midpacket_reset", 32'(req_ready), 32'd1);
    send(4'd7, 12'd2, 0);
    drain();
    check(last_hdr[8:1] == 8'd0, "seq_after_reset", 32'(last_hdr[8:1]), 32'd0);

    // Sequence wrap: 256 more packets take seq back around to 0.
    rand_dcts = 1;
    for (int k = 0; k < 256; k++) send(4'($urandom_range(15)), 12'd1, 0);
    drain();
    check(last_hdr[8:1] == 8'd0, "seq_wrap", 32'(last_hdr[8:1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/noc_packet_injector.md
NOC_PACKET_INJECTOR -- requirements
Module: noc_packet_injector

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the flit width; only 32 is supported.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous and active-low.
- cur_addr  in  4  own node address; static after reset.
- req_valid  in  1  packet request valid.
- req_ready  out  1  request accepted when high together with req_valid.
- req_dst  in  4  destination address.
- req_len  in  12  payload flit count N.
- pay_valid  in  1  payload word valid.
- pay_ready  out  1  payload word consumed when high together with pay_valid.
- pay_data  in  28  payload word.
- TX  out  32  flit to the router local input port (router L_RX).
- RTS  out  1  flit strobe to the router (router L_DRTS).
- DCTS  in  1  router local input FIFO ready (router L_CTS).
- pkt_sent  out  1  one-cycle pulse when the tail flit is issued.
- err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-003 Header flit layout SHALL be:
- [31:29] = 3'b001
- [28:17] = N+1 (total flits)
- [16:13] = req_dst
- [12:9] = cur_addr
- [8:1] = seq
- [0] = parity
REQ-004 Body flit layout SHALL be [31:29]=3'b010, [28:1]=pay_data, [0]=parity; the tail flit is identical except [31:29]=3'b100.
REQ-005 Parity bit [0] SHALL be the XOR of bits [31:1], so the XOR of all 32 bits is 0.
REQ-006 The FSM SHALL have three states: IDLE, HDR and PAY.
REQ-007 In IDLE, req_ready SHALL be 1; in all other states, req_ready SHALL be 0.
REQ-008 In IDLE, on req_valid&&req_ready, req_dst and req_len SHALL be latched.
REQ-009 On acceptance in IDLE, if 1<=N<=4094 the FSM SHALL go to HDR; otherwise (N=0 or N=4095) err SHALL pulse the next cycle, no flit SHALL be issued, and the FSM SHALL stay in IDLE.
REQ-010 In HDR, on a rising edge with DCTS=1, the header SHALL be registered onto TX with RTS=1, the remaining count SHALL be loaded with N, and the FSM SHALL go to PAY; with DCTS=0 the FSM SHALL hold with RTS=0.
REQ-011 In PAY, pay_ready SHALL equal DCTS (combinational); in all other states, pay_ready SHALL be 0.
REQ-012 In PAY, on pay_valid&&pay_ready, a body flit SHALL be issued if the count is >1, otherwise a tail flit.
REQ-013 On each payload flit issued in PAY, the count SHALL decrement.
REQ-014 On the tail flit: the FSM SHALL return to IDLE, pkt_sent SHALL pulse in the same cycle as the tail's RTS, and seq SHALL increment (wrapping 255->0).
REQ-015 RTS SHALL be registered, high for exactly one cycle per flit.
- Back-to-back flits on consecutive cycles are permitted while DCTS stays 1.
- RTS SHALL be 0 in every cycle without a new flit.
REQ-016 TX SHALL hold its last value when RTS=0.
REQ-017 If DCTS falls during PAY, issue SHALL stall with no flit lost or duplicated.
REQ-018 Payload starvation (pay_valid=0) SHALL stall indefinitely with RTS=0; there is no timeout.
REQ-019 req_dst equal to cur_addr SHALL be legal and packetised normally.
REQ-020 A new request SHALL NOT be accepted in the same cycle the tail is issued; the earliest acceptance is the following cycle, in IDLE.
REQ-021 Latency from request acceptance to header RTS SHALL be 2 cycles with DCTS held at 1.
REQ-022 Latency from payload handshake to its flit RTS SHALL be 1 cycle.

Reset
REQ-023 With rst=0, the block SHALL asynchronously force state=IDLE, TX=0, RTS=0, pkt_sent=0, err=0, seq=0 and count=0.
REQ-024 Reset asserted mid-packet SHALL abort the packet with RTS=0 immediately; a truncated packet at the router is the system's responsibility.
REQ-025 After rst deasserts, req_ready SHALL be 1 on the first clock.

Verification
REQ-026 Basic packet: cur_addr=1, req_dst=2, req_len=3, DCTS=1, three payload words 0x0000001,0x0000002,0x0000003 -> four RTS pulses on consecutive cycles; header TX=0x20084200; flit types 001,010,010,100; pkt_sent coincides with the tail; every flit has XOR of 32 bits = 0.
REQ-027 Backpressure: DCTS=0 for 5 cycles mid-payload -> no RTS and pay_ready=0 during the stall; resumes with no loss or duplication; flit order intact.
REQ-028 Boundary lengths:
- req_len=1 -> header (length field 2) then tail only.
- req_len=0 -> err pulse and no RTS.
- req_len=4095 -> err pulse and no RTS.
- req_len=4094 -> length field 4095 and 4094 payload flits.
REQ-029 Sequence wrap: send 257 packets -> header seq values 0..255, then 0.
REQ-030 Reset mid-packet: rst=0 after the header and one body flit -> RTS=0 asynchronously; after release, a new request is accepted and its header carries seq=0.
